// File: rtl/dec_counter_pkg.sv
// Shared definitions for the dec_counter down-counter: underflow policy encoding.
package dec_counter_pkg;

  typedef enum logic [1:0] {
    ModeWrap   = 2'd0,
    ModeSat    = 2'd1,
    ModeReload = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  localparam int unsigned DefaultWidth = 20;
  localparam int unsigned DefaultStepW = 4;

endpackage

// File: rtl/dec_counter_if.sv
// Control/status bundle of dec_counter; the master drives requests, the counter is the slave.
interface dec_counter_if #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned STEP_W = 4
);

    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  count;
    logic              borrow;
    logic              zero;
    logic              tc_pulse;

    modport master (
        output load, load_val, en, step, mode,
        input  count, borrow, zero, tc_pulse
    );

    modport slave (
        input  load, load_val, en, step, mode,
        output count, borrow, zero, tc_pulse
    );

endinterface

// File: rtl/dec_core.sv
// Combinational subtractor a - b; borrow_o flags a < b (generalised decrementer).
module dec_core #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH:0] full;

    assign full     = {1'b0, a_i} - {1'b0, b_i};
    assign diff_o   = full[WIDTH-1:0];
    assign borrow_o = full[WIDTH];

endmodule

// File: rtl/dec_counter.sv
// Registered down-counter with load, variable step and wrap/saturate/reload underflow policy.
module dec_counter
    import dec_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STEP_W = DefaultStepW
) (
    input  logic          clk,
    input  logic          rst_n,
    dec_counter_if.slave  bus_io
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] diff;
    logic             under;
    mode_e            mode;

    assign step_ext = WIDTH'(bus_io.step);
    assign mode     = mode_e'(bus_io.mode);

    dec_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (count_q),
        .b_i      (step_ext),
        .diff_o   (diff),
        .borrow_o (under)
    );

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        tc_d     = 1'b0;
        if (bus_io.load) begin
            count_d  = bus_io.load_val;
            reload_d = bus_io.load_val;
        end else if (bus_io.en && (step_ext != '0)) begin
            if (under) begin
                borrow_d = 1'b1;
                tc_d     = 1'b1;
                unique case (mode)
                    ModeSat:    count_d = '0;
                    ModeReload: count_d = reload_q;
                    ModeWrap,
                    ModeRsvd:   count_d = diff;
                endcase
            end else begin
                // Exact hit on zero still fires the terminal-count pulse.
                count_d = diff;
                tc_d    = (diff == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
            tc_q     <= tc_d;
        end
    end

    assign bus_io.count    = count_q;
    assign bus_io.borrow   = borrow_q;
    assign bus_io.tc_pulse = tc_q;
    assign bus_io.zero     = (count_q == '0);

endmodule

// File: tb/tb_dec_counter.sv
// Randomised and directed checks of dec_counter against an arithmetic reference model.
module tb_dec_counter;

    localparam int unsigned W  = 20;
    localparam int unsigned SW = 4;
    localparam longint Mod = 64'd1 << W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dec_counter_if #(.WIDTH(W), .STEP_W(SW)) bus ();

    dec_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    longint m_count  = 0;
    longint m_reload = 0;
    bit     m_borrow = 0;
    bit     m_tc     = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_val({tag, ".count"},  32'(bus.count),    32'(m_count));
        check_val({tag, ".borrow"}, 32'(bus.borrow),   32'(m_borrow));
        check_val({tag, ".tc"},     32'(bus.tc_pulse), 32'(m_tc));
        check_val({tag, ".zero"},   32'(bus.zero),     32'(m_count == 0));
    endtask

    // Reference: count as a plain integer, underflow when step exceeds it.
    task automatic model_update(input bit ld, input longint lv, input bit e,
                                input longint st, input int md);
        m_borrow = 0;
        m_tc     = 0;
        if (ld) begin
            m_count  = lv;
            m_reload = lv;
        end else if (e && st != 0) begin
            if (st > m_count) begin
                m_borrow = 1;
                m_tc     = 1;
                if (md == 1)      m_count = 0;
                else if (md == 2) m_count = m_reload;
                else              m_count = (m_count + Mod - st) % Mod;
            end else begin
                m_count = m_count - st;
                m_tc    = (m_count == 0);
            end
        end
    endtask

    task automatic cyc(input string tag, input bit ld, input logic [W-1:0] lv, input bit e,
                       input logic [SW-1:0] st, input logic [1:0] md);
        bus.load     = ld;
        bus.load_val = lv;
        bus.en       = e;
        bus.step     = st;
        bus.mode     = md;
        @(posedge clk);
        model_update(ld, longint'(lv), e, longint'(st), int'(md));
        @(negedge clk);
        check_model(tag);
    endtask

    // Asserts reset between edges and checks that it bites without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_val({tag, ".count"},  32'(bus.count),    32'd0);
        check_val({tag, ".borrow"}, 32'(bus.borrow),   32'd0);
        check_val({tag, ".tc"},     32'(bus.tc_pulse), 32'd0);
        m_count = 0; m_reload = 0; m_borrow = 0; m_tc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] lv;
        bus.load = 0; bus.load_val = '0; bus.en = 0; bus.step = '0; bus.mode = 2'd0;

        #3;
        check_val("rst.count", 32'(bus.count), 32'd0);
        check_val("rst.zero",  32'(bus.zero),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 0, '0, 0, 4'd0, 2'd0);

        // 1: reset mid-count, also while borrow/tc are high
        cyc("t1.load", 1, 20'h0005A, 0, 4'd0, 2'd0);
        cyc("t1.dec", 0, '0, 1, 4'd5, 2'd0);
        check_val("t1.at55", 32'(bus.count), 32'h55);
        async_reset("t1.rst");
        cyc("t1b.load", 1, 20'h00001, 0, 4'd0, 2'd0);
        cyc("t1b.under", 0, '0, 1, 4'd2, 2'd0);
        async_reset("t1b.rst");

        // 2: countdown to exact zero
        cyc("t2.load", 1, 20'h00003, 0, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++) cyc("t2.dec", 0, '0, 1, 4'd1, 2'd0);
        check_val("t2.tc3", 32'(bus.tc_pulse), 32'd1);

        // 3: WRAP
        cyc("t3.load", 1, 20'h00002, 0, 4'd0, 2'd0);
        cyc("t3.wrap", 0, '0, 1, 4'd5, 2'd0);
        check_val("t3.count", 32'(bus.count), 32'hFFFFD);
        cyc("t3.hold", 0, '0, 0, 4'd5, 2'd0);
        check_val("t3.tc_gone", 32'(bus.tc_pulse), 32'd0);

        // 4: SAT, then underflow again from zero
        cyc("t4.load", 1, 20'h00001, 0, 4'd0, 2'd0);
        cyc("t4.sat", 0, '0, 1, 4'hF, 2'd1);
        cyc("t4.sat0", 0, '0, 1, 4'hF, 2'd1);
        check_val("t4.borrow", 32'(bus.borrow), 32'd1);

        // 5: RELOAD
        cyc("t5.load", 1, 20'h00010, 0, 4'd0, 2'd2);
        cyc("t5.d1", 0, '0, 1, 4'd8, 2'd2);
        cyc("t5.d2", 0, '0, 1, 4'd8, 2'd2);
        cyc("t5.rl", 0, '0, 1, 4'd8, 2'd2);
        check_val("t5.count", 32'(bus.count), 32'h10);

        // 6: load beats en; zero step holds
        cyc("t6.lden", 1, 20'hFFFFF, 1, 4'd3, 2'd0);
        cyc("t6.step0", 0, '0, 1, 4'd0, 2'd0);
        check_val("t6.count", 32'(bus.count), 32'hFFFFF);

        // reserved mode behaves as wrap
        cyc("rsvd.load", 1, 20'h00001, 0, 4'd0, 2'd3);
        cyc("rsvd.wrap", 0, '0, 1, 4'd3, 2'd3);

        for (int i = 0; i < 400; i++) begin
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
            cyc("rand", ($urandom_range(0, 7) == 0), lv, ($urandom_range(0, 3) != 0),
                SW'($urandom), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
